mux8_scan_ctrl: RTL and testbench

- Upstream/downstream companion to the 8:1 mux.
- Sequences the select lines {s0,s1,s2} through channels 0..7, waits a programmable settle time on each channel, then samples the mux output y.
- Packs the eight samples into one 8-bit frame, handed downstream through a valid/ready handshake.
- Turns the combinational mux into a time-multiplexed 8-channel input scanner.

---
 rtl/mux8_scan_ctrl_if.sv | 12 +
 rtl/mux8_scan_ctrl.sv | 106 ++++++++++
 tb/tb_mux8_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux8_scan_ctrl_if.sv
// Frame hand-off bundle between the scanner and its downstream consumer.
// Latency: none, this is wiring only.
// Backpressure: frame_ready from the consumer; the scanner itself never stalls on it.
// Signals: frame[7:0] packed channel samples, frame_valid result pending, frame_ready consumer accepts.
interface mux8_scan_ctrl_if;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_ready;

  modport master (output frame, output frame_valid, input frame_ready);
  modport slave  (input frame, input frame_valid, output frame_ready);
endinterface

// File: rtl/mux8_scan_ctrl.sv
// Time-multiplexed 8-channel scanner: walks an 8:1 mux select, settles, samples y, packs a frame.
// Latency: frame lands 8*(dwell+2) cycles after start is accepted; continuous frames back to back.
// Backpressure: none taken; an unconsumed frame is overwritten and overrun is flagged (sticky).
// Ports: clk/rst (sync active-high); start, cont, dwell control inputs; y mux output in;
//        s0/s1/s2 select out (s0 = channel bit 2); busy, overrun status; fo = frame handshake.
module mux8_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic               busy,
  output logic               overrun,
  mux8_scan_ctrl_if.master   fo
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [2:0]         ch;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_r;
  logic [6:0]         shadow;
  logic [7:0]         frame_q;
  logic               frame_valid_q;
  logic               land;

  // A frame completes on the sample cycle of the last channel.
  assign land = (state == ST_SAMPLE) && (ch == 3'd7);

  assign {s0, s1, s2}   = ch;
  assign busy           = (state != ST_IDLE);
  assign fo.frame       = frame_q;
  assign fo.frame_valid = frame_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ch            <= 3'd0;
      cnt           <= '0;
      dwell_r       <= '0;
      shadow        <= 7'd0;
      frame_q       <= 8'h00;
      frame_valid_q <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ch <= 3'd0;
          if (start) begin
            dwell_r <= dwell;
            cnt     <= '0;
            overrun <= 1'b0;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == dwell_r) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          cnt <= '0;
          if (ch != 3'd7) begin
            shadow[ch] <= y;
            ch         <= ch + 3'd1;
            state      <= ST_SETTLE;
          end else begin
            // cont is a level looked at only here, so dropping it lets the
            // frame in flight finish before returning to idle.
            ch    <= 3'd0;
            state <= cont ? ST_SETTLE : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          ch    <= 3'd0;
        end
      endcase

      // A landing frame wins over a same-edge accept: valid stays high with
      // the new data, and it is not an overrun because the old one was taken.
      if (land) begin
        frame_q       <= {y, shadow};
        frame_valid_q <= 1'b1;
        if (frame_valid_q && !fo.frame_ready) begin
          overrun <= 1'b1;
        end
      end else if (frame_valid_q && fo.frame_ready) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
module tb_mux8_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cont;
  logic [3:0] dwell;
  logic       y;
  logic       s0, s1, s2;
  logic       busy;
  logic       overrun;
  logic [7:0] mux_in;

  int checks;
  int failures;

  mux8_scan_ctrl_if fif ();

  mux8_scan_ctrl #(.DWELL_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cont    (cont),
    .dwell   (dwell),
    .y       (y),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .busy    (busy),
    .overrun (overrun),
    .fo      (fif.master)
  );

  // Behavioural 8:1 mux: channel index is {s0,s1,s2}.
  assign y = mux_in[{s0, s1, s2}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if ({s0, s1, s2} !== 3'b000 || fif.frame !== 8'h00 || fif.frame_valid !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: sel=%b frame=%h fv=%b busy=%b ovr=%b, need 000/00/0/0/0",
               {s0, s1, s2}, fif.frame, fif.frame_valid, busy, overrun);
    end
  endtask

  // Single-frame scan; expected select at k cycles after the accepting edge is
  // k/(d+2), and the frame must equal the held mux inputs after 8*(d+2) cycles.
  task automatic run_scan(input int d, input logic [7:0] v, input bit poke, input string nm);
    int len;
    logic [2:0] exp_sel;
    len = 8 * (d + 2);
    mux_in = v;
    dwell = d[3:0];
    cont = 1'b0;
    fif.frame_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      exp_sel = 3'(k / (d + 2));
      checks++;
      if ({s0, s1, s2} !== exp_sel || busy !== 1'b1 || fif.frame_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_step k=%0d: sel=%b busy=%b fv=%b, need sel=%b busy=1 fv=0",
                 nm, k, {s0, s1, s2}, busy, fif.frame_valid, exp_sel);
      end
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        dwell = 4'($urandom);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (fif.frame_valid !== 1'b1 || fif.frame !== v || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_frame: fv=%b frame=%h busy=%b, need fv=1 frame=%h busy=0",
               nm, fif.frame_valid, fif.frame, busy, v);
    end
    tick();
    checks++;
    if (fif.frame_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse: fv=%b busy=%b one cycle later, need fv=0 busy=0",
               nm, fif.frame_valid, busy);
    end
  endtask

  task automatic test_single_scan();
    run_scan(0, 8'hA6, 1'b0, "single");
  endtask

  task automatic test_dwell_timing();
    run_scan(3, 8'hA6, 1'b1, "dwell3");
  endtask

  task automatic test_random_scans();
    for (int i = 0; i < 4; i++) begin
      run_scan(int'($urandom_range(0, 15)), 8'($urandom), 1'b1, "rand");
    end
  endtask

  task automatic test_cont_backpressure();
    mux_in = 8'hA6;
    dwell = 4'd0;
    cont = 1'b1;
    fif.frame_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    checks++;
    if (fif.frame_valid !== 1'b1 || fif.frame !== 8'hA6 || overrun !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL cont_first: fv=%b frame=%h ovr=%b busy=%b, need 1/a6/0/1",
               fif.frame_valid, fif.frame, overrun, busy);
    end
    mux_in = 8'h5B;
    for (int k = 17; k < 32; k++) begin
      tick();
      checks++;
      if (fif.frame_valid !== 1'b1 || fif.frame !== 8'hA6) begin
        failures++;
        $display("FAIL cont_hold k=%0d: fv=%b frame=%h, need 1/a6", k, fif.frame_valid, fif.frame);
      end
    end
    tick();
    checks++;
    if (fif.frame_valid !== 1'b1 || fif.frame !== 8'h5B || overrun !== 1'b1) begin
      failures++;
      $display("FAIL cont_overrun: fv=%b frame=%h ovr=%b, need 1/5b/1",
               fif.frame_valid, fif.frame, overrun);
    end
    fif.frame_ready = 1'b1;
    tick();
    checks++;
    if (fif.frame_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL cont_accept: fv=%b ovr=%b, need fv=0 ovr=1 (sticky)", fif.frame_valid, overrun);
    end
    cont = 1'b0;
    repeat (15) tick();
    checks++;
    if (fif.frame_valid !== 1'b1 || fif.frame !== 8'h5B || busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_drop: fv=%b frame=%h busy=%b, need 1/5b/0",
               fif.frame_valid, fif.frame, busy);
    end
    tick();
    checks++;
    if (fif.frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL cont_drop_clear: fv=%b, need 0", fif.frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    int len;
    logic [7:0] a;
    logic [7:0] b;
    d = int'($urandom_range(0, 3));
    len = 8 * (d + 2);
    a = 8'($urandom);
    b = ~a;
    mux_in = a;
    dwell = d[3:0];
    cont = 1'b1;
    fif.frame_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (len) tick();
    checks++;
    if (fif.frame_valid !== 1'b1 || fif.frame !== a || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: fv=%b frame=%h ovr=%b, need 1/%h/0",
               fif.frame_valid, fif.frame, overrun, a);
    end
    mux_in = b;
    repeat (len - 1) tick();
    fif.frame_ready = 1'b1;
    tick();
    checks++;
    if (fif.frame_valid !== 1'b1 || fif.frame !== b || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_collide: fv=%b frame=%h ovr=%b, need 1/%h/0",
               fif.frame_valid, fif.frame, overrun, b);
    end
    cont = 1'b0;
    tick();
    checks++;
    if (fif.frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_clear: fv=%b, need 0", fif.frame_valid);
    end
    repeat (len - 1) tick();
    checks++;
    if (fif.frame_valid !== 1'b1 || fif.frame !== b || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_last: fv=%b frame=%h busy=%b, need 1/%h/0",
               fif.frame_valid, fif.frame, busy, b);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    mux_in = 8'($urandom);
    dwell = 4'd2;
    cont = 1'b0;
    fif.frame_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    checks++;
    if ({s0, s1, s2} !== 3'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: sel=%b busy=%b, need 100/1", {s0, s1, s2}, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({s0, s1, s2} !== 3'b000 || busy !== 1'b0 || fif.frame_valid !== 1'b0 ||
        fif.frame !== 8'h00 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL midrst_post: sel=%b busy=%b fv=%b frame=%h ovr=%b, need 000/0/0/00/0",
               {s0, s1, s2}, busy, fif.frame_valid, fif.frame, overrun);
    end
    tick();
    run_scan(2, 8'($urandom), 1'b0, "after_rst");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    cont = 1'b0;
    dwell = 4'd0;
    mux_in = 8'h00;
    fif.frame_ready = 1'b0;
    test_reset();
    test_single_scan();
    test_dwell_timing();
    test_random_scans();
    test_cont_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
